axi_addr_remapper: RTL and testbench
====================================

# axi_addr_remapper

Multi-window AXI address translator that replaces the single-offset address hijacker between the PS high-performance AXI port and the emulated flash/memory slaves. It sits on the AW and AR channels of one AXI master link and maps each address through NUM_WINDOWS run-time-programmable windows (base/mask/offset). Each channel has a one-entry register slice. Windows are programmed by the PS over an AXI4-Lite configuration slave. Unmatched addresses pass through unchanged and are counted for debug.

## Interface
- ADDR_WIDTH, 32: AXI address width on the translated link.
- USER_WIDTH, 32: width of the opaque AW/AR sideband bundle (id, len, size, burst, …) carried alongside the address.
- NUM_WINDOWS, 4: number of translation windows, 1..8.
- CFG_ADDR_WIDTH, 7: config byte-address width; must be ≥ clog2(16*(NUM_WINDOWS+1)).
- clk_i  in  1  single clock for all logic.
- rst_ni  in  1  asynchronous active-low reset.
- up_aw_addr_i / up_aw_user_i / up_aw_valid_i  in  ADDR_WIDTH / USER_WIDTH / 1  upstream write-address channel.
- up_aw_ready_o  out  1  upstream AW ready.
- dn_aw_addr_o / dn_aw_user_o / dn_aw_valid_o  out  ADDR_WIDTH / USER_WIDTH / 1  translated AW to the slave.
- dn_aw_ready_i  in  1  downstream AW ready.
- up_ar_* / dn_ar_*: identical set for the read-address channel.
- s_cfg_awaddr, s_cfg_araddr  in  CFG_ADDR_WIDTH  config addresses.
- s_cfg_awvalid, s_cfg_wvalid, s_cfg_bready, s_cfg_arvalid, s_cfg_rready  in  1  config handshakes.
- s_cfg_wdata  in  32;  s_cfg_wstrb  in  4.
- s_cfg_awready, s_cfg_wready, s_cfg_bvalid, s_cfg_arready, s_cfg_rvalid  out  1.
- s_cfg_bresp, s_cfg_rresp  out  2;  s_cfg_rdata  out  32.

## Operation
- Register map. Word-aligned; address bits [1:0] are ignored.
  - 0x00 GCTRL: bit0 = global enable, RW.
  - 0x04 MISS_CNT: RO; any write clears it to 0.
  - 0x08 LAST_MISS: RO; low 32 bits of the last missed address.
  - Window w at 0x10+0x10*w: +0x0 BASE, +0x4 MASK, +0x8 OFFSET, +0xC WCTRL (bit0 enable). All RW.
  - Registers are ADDR_WIDTH wide when ADDR_WIDTH ≤ 32. The upper bits of wider fields are zero.
- Reset: every register is 0, so all windows and the global enable are off. All valid outputs are 0, and s_cfg_awready, s_cfg_wready and s_cfg_arready are 0.
- Match rule: window w hits when WCTRL[w].en and (addr & MASK) == (BASE & MASK). If several windows hit, the lowest index wins.
- Translation: on a hit, out = (addr + OFFSET) mod 2^ADDR_WIDTH, with wrap-around and no error.
- Global enable 0: all addresses pass through unchanged and no misses are counted.
- Global enable 1 with no hit: the address passes through unchanged. MISS_CNT increments, saturating at 0xFFFFFFFF, and LAST_MISS records the address.
- Misses on AW and AR in the same cycle: MISS_CNT increments by 2 (saturating) and LAST_MISS records the AW address.
- A MISS_CNT clear coincident with a miss leaves the count at the miss increment.
- Config FSM, write path:
  - IDLE asserts awready and wready only while both awvalid and wvalid are high; both are accepted in the same cycle.
  - The write is applied with wstrb byte enables, then the FSM moves to WRESP, which holds bvalid until bready.
  - Reads are blocked while in WRESP.
- Config FSM, read path:
  - IDLE accepts arvalid and moves to RDATA, which holds rvalid and rdata stable until rready.
  - If write and read requests arrive together in IDLE, the write goes first.
- Out-of-range config address: writes are ignored, reads return 0; resp = SLVERR (2'b10). All other accesses return OKAY.

## Timing
- Translation latency is 1 cycle per channel. The address and user fields are captured into the slice on the up handshake; dn_*_valid_o rises the next cycle.
- Slice behaviour: up_*_ready_o = !full || dn_*_ready_i. This gives full throughput (one beat per cycle) under continuous downstream ready.
- Downstream handshake: dn outputs hold stable while dn valid is high and ready is low.
- Configuration used: translation uses register values sampled in the cycle of the up handshake. A config write that completes in the same cycle affects only later beats.
- Config write to register update: 1 cycle after the aw/w accept. The bvalid cycle coincides with the new value being visible.
- Reset asserted mid-transfer: slices are cleared immediately (asynchronously) and all valids drop. The in-flight beat is lost, and upstream must re-issue it.

## Structure
- Package axi_addr_remapper_pkg holds:
  - register offset constants (GCTRL, MISS_CNT, LAST_MISS, WIN_STRIDE, WIN_BASE_OFS, …);
  - the window_cfg_t struct {base, mask, offset, en};
  - the config FSM state enum {IDLE, WRESP, RDATA}.
- Sub-module axi_addr_remap_chan: one register slice plus the match/translate logic. It is instantiated twice (AW and AR), takes the window_cfg_t array as input, and outputs a miss pulse and the miss address.
- The top level contains the AXI-Lite register file, the FSM, and the miss counter.

## Test plan
- Reset then traffic: after reset, program nothing; send AR 0x1000_0040 → dn_ar_addr 0x1000_0040 after 1 cycle, MISS_CNT reads 0.
- Basic window: program window 0 with BASE 0x0000_0000, MASK 0xFF00_0000, OFFSET 0x1800_0000, en=1, GCTRL=1; send AW 0x0000_1234 → dn 0x1800_1234.
- Priority: with windows 0 and 1 both matching 0x2000_0000, window 1 OFFSET 0x10 and window 0 OFFSET 0x20 → output 0x2000_0020. Check 0xFFFF_FFF0 + OFFSET 0x20 wraps to 0x0000_0010.
- Miss accounting: GCTRL=1 and same-cycle misses AW 0xA000_0000 and AR 0xB000_0000 → MISS_CNT=2, LAST_MISS=0xA000_0000. A write to 0x04 then reads back 0.
- Backpressure: hold dn_aw_ready_i=0 for 5 cycles with two up beats → first beat stable on dn, up_aw_ready_o=0 after the first accept. Then release ready → both beats delivered in order, 1 per cycle.
- Config protocol: send awvalid with wvalid delayed 3 cycles → no accept until both are high. Read 0x7C (out of range) → rdata 0, rresp 2'b10. Write with wstrb=4'b0010 → only byte 1 changes.

Source files
------------

// File: rtl/axi_addr_remapper_pkg.sv
// Shared types, register offsets and small helpers for the multi-window AXI address remapper.
// Register fields are held 32 bits wide and narrowed to the link width where they are used.
package axi_addr_remapper_pkg;

   localparam int unsigned GctrlOfs    = 32'h00;
   localparam int unsigned MissCntOfs  = 32'h04;
   localparam int unsigned LastMissOfs = 32'h08;
   localparam int unsigned WinBaseOfs  = 32'h10;
   localparam int unsigned WinStride   = 32'h10;

   localparam logic [3:0] BaseOfs   = 4'h0;
   localparam logic [3:0] MaskOfs   = 4'h4;
   localparam logic [3:0] OffsetOfs = 4'h8;
   localparam logic [3:0] WctrlOfs  = 4'hC;

   localparam logic [1:0] RespOkay   = 2'b00;
   localparam logic [1:0] RespSlverr = 2'b10;

   typedef struct packed {
      logic [31:0] base;
      logic [31:0] mask;
      logic [31:0] offset;
      logic        en;
   } window_cfg_t;

   typedef enum logic [1:0] {StIdle, StWresp, StRdata} cfg_state_e;

   typedef struct packed {
      logic       valid;
      logic       is_win;
      logic [2:0] win;
      logic [3:0] field;
   } cfg_dec_t;

   // ba is a word-aligned byte address
   function automatic cfg_dec_t cfg_decode(input logic [31:0] ba, input int unsigned num_windows);
      cfg_dec_t    d;
      logic [31:0] rel;
      d   = '0;
      rel = ba - WinBaseOfs;
      if (ba >= WinBaseOfs) begin
         if ((rel / WinStride) < num_windows) begin
            d.valid  = 1'b1;
            d.is_win = 1'b1;
            d.win    = 3'(rel / WinStride);
            d.field  = 4'(rel % WinStride);
         end
      end else if (ba == GctrlOfs || ba == MissCntOfs || ba == LastMissOfs) begin
         d.valid = 1'b1;
      end
      return d;
   endfunction

   function automatic logic [31:0] apply_strb(input logic [31:0] old, input logic [31:0] wdata,
                                              input logic [3:0] strb);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++) begin
         if (strb[b]) r[8*b +: 8] = wdata[8*b +: 8];
      end
      return r;
   endfunction

endpackage

// File: rtl/axi_addr_remap_chan.sv
// One address channel: window match/translate on the upstream beat, then a one-entry slice.
// Reports a miss pulse with the untranslated address when enabled and no window hits.
module axi_addr_remap_chan
   import axi_addr_remapper_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH  = 32,
   parameter int unsigned USER_WIDTH  = 32,
   parameter int unsigned NUM_WINDOWS = 4
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic                               glb_en,
   input  window_cfg_t [NUM_WINDOWS-1:0]      win,
   input  logic [ADDR_WIDTH-1:0]              up_addr,
   input  logic [USER_WIDTH-1:0]              up_user,
   input  logic                               up_valid,
   output logic                               up_ready,
   output logic [ADDR_WIDTH-1:0]              dn_addr,
   output logic [USER_WIDTH-1:0]              dn_user,
   output logic                               dn_valid,
   input  logic                               dn_ready,
   output logic                               miss,
   output logic [31:0]                        miss_addr
);

   logic                  full_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [USER_WIDTH-1:0] user_q;
   logic                  hit;
   logic                  up_hs;
   logic [ADDR_WIDTH-1:0] xlat;

   always_comb begin
      hit  = 1'b0;
      xlat = up_addr;
      // Descending scan so the lowest matching index is applied last and wins
      for (int w = NUM_WINDOWS - 1; w >= 0; w--) begin
         if (glb_en && win[w].en &&
             ((up_addr & ADDR_WIDTH'(win[w].mask)) ==
              (ADDR_WIDTH'(win[w].base) & ADDR_WIDTH'(win[w].mask)))) begin
            hit  = 1'b1;
            xlat = up_addr + ADDR_WIDTH'(win[w].offset);
         end
      end
   end

   assign up_ready  = !full_q || dn_ready;
   assign up_hs     = up_valid && up_ready;
   assign miss      = up_hs && glb_en && !hit;
   assign miss_addr = 32'(up_addr);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         full_q <= 1'b0;
         addr_q <= '0;
         user_q <= '0;
      end else if (up_hs) begin
         full_q <= 1'b1;
         addr_q <= xlat;
         user_q <= up_user;
      end else if (dn_ready) begin
         full_q <= 1'b0;
      end
   end

   assign dn_valid = full_q;
   assign dn_addr  = addr_q;
   assign dn_user  = user_q;

endmodule

// File: rtl/axi_addr_remapper.sv
// Multi-window AXI AW/AR address translator with an AXI4-Lite register file for the windows
// and miss accounting for unmatched addresses.
module axi_addr_remapper
   import axi_addr_remapper_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH     = 32,
   parameter int unsigned USER_WIDTH     = 32,
   parameter int unsigned NUM_WINDOWS    = 4,
   parameter int unsigned CFG_ADDR_WIDTH = 7
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   input  logic [ADDR_WIDTH-1:0]     up_aw_addr_i,
   input  logic [USER_WIDTH-1:0]     up_aw_user_i,
   input  logic                      up_aw_valid_i,
   output logic                      up_aw_ready_o,
   output logic [ADDR_WIDTH-1:0]     dn_aw_addr_o,
   output logic [USER_WIDTH-1:0]     dn_aw_user_o,
   output logic                      dn_aw_valid_o,
   input  logic                      dn_aw_ready_i,
   input  logic [ADDR_WIDTH-1:0]     up_ar_addr_i,
   input  logic [USER_WIDTH-1:0]     up_ar_user_i,
   input  logic                      up_ar_valid_i,
   output logic                      up_ar_ready_o,
   output logic [ADDR_WIDTH-1:0]     dn_ar_addr_o,
   output logic [USER_WIDTH-1:0]     dn_ar_user_o,
   output logic                      dn_ar_valid_o,
   input  logic                      dn_ar_ready_i,
   input  logic [CFG_ADDR_WIDTH-1:0] s_cfg_awaddr,
   input  logic                      s_cfg_awvalid,
   output logic                      s_cfg_awready,
   input  logic [31:0]               s_cfg_wdata,
   input  logic [3:0]                s_cfg_wstrb,
   input  logic                      s_cfg_wvalid,
   output logic                      s_cfg_wready,
   output logic [1:0]                s_cfg_bresp,
   output logic                      s_cfg_bvalid,
   input  logic                      s_cfg_bready,
   input  logic [CFG_ADDR_WIDTH-1:0] s_cfg_araddr,
   input  logic                      s_cfg_arvalid,
   output logic                      s_cfg_arready,
   output logic [31:0]               s_cfg_rdata,
   output logic [1:0]                s_cfg_rresp,
   output logic                      s_cfg_rvalid,
   input  logic                      s_cfg_rready
);

   localparam logic [31:0] RegMask =
      (ADDR_WIDTH >= 32) ? 32'hFFFF_FFFF : 32'((64'd1 << ADDR_WIDTH) - 64'd1);

   cfg_state_e                    state_q, state_d;
   logic                          gctrl_q, gctrl_d;
   logic [31:0]                   miss_cnt_q, miss_cnt_d, last_miss_q, last_miss_d;
   window_cfg_t [NUM_WINDOWS-1:0] win_q, win_d;
   logic [1:0]                    bresp_q, bresp_d, rresp_q, rresp_d;
   logic [31:0]                   rdata_q, rdata_d;
   logic                          wr_acc, rd_acc, miss_clr;
   logic [31:0]                   wr_ba, rd_ba, wr_new, rd_val;
   cfg_dec_t                      wr_dec, rd_dec;
   logic                          aw_miss, ar_miss;
   logic [31:0]                   aw_miss_addr, ar_miss_addr;
   logic [32:0]                   miss_sum;
   logic                          unused_cfg_lsbs;

   function automatic logic [31:0] reg_read(input cfg_dec_t d, input logic [31:0] ba);
      logic [31:0] v;
      v = '0;
      if (d.valid && !d.is_win) begin
         if (ba == GctrlOfs)    v = {31'b0, gctrl_q};
         if (ba == MissCntOfs)  v = miss_cnt_q;
         if (ba == LastMissOfs) v = last_miss_q;
      end else if (d.valid) begin
         for (int w = 0; w < NUM_WINDOWS; w++) begin
            if (d.win == 3'(w)) begin
               case (d.field)
                  BaseOfs:   v = win_q[w].base;
                  MaskOfs:   v = win_q[w].mask;
                  OffsetOfs: v = win_q[w].offset;
                  WctrlOfs:  v = {31'b0, win_q[w].en};
                  default:   v = '0;
               endcase
            end
         end
      end
      return v;
   endfunction

   assign unused_cfg_lsbs = ^{s_cfg_awaddr[1:0], s_cfg_araddr[1:0]};
   assign wr_ba  = 32'({s_cfg_awaddr[CFG_ADDR_WIDTH-1:2], 2'b00});
   assign rd_ba  = 32'({s_cfg_araddr[CFG_ADDR_WIDTH-1:2], 2'b00});
   assign wr_dec = cfg_decode(wr_ba, NUM_WINDOWS);
   assign rd_dec = cfg_decode(rd_ba, NUM_WINDOWS);
   assign wr_new = apply_strb(reg_read(wr_dec, wr_ba), s_cfg_wdata, s_cfg_wstrb);
   assign rd_val = reg_read(rd_dec, rd_ba);

   // Writes take priority over reads when both are pending in idle
   always_comb begin
      state_d       = state_q;
      s_cfg_awready = 1'b0;
      s_cfg_wready  = 1'b0;
      s_cfg_arready = 1'b0;
      s_cfg_bvalid  = (state_q == StWresp);
      s_cfg_rvalid  = (state_q == StRdata);
      case (state_q)
         StIdle: begin
            if (s_cfg_awvalid && s_cfg_wvalid) begin
               s_cfg_awready = 1'b1;
               s_cfg_wready  = 1'b1;
               state_d       = StWresp;
            end else if (s_cfg_arvalid) begin
               s_cfg_arready = 1'b1;
               state_d       = StRdata;
            end
         end
         StWresp: if (s_cfg_bready) state_d = StIdle;
         StRdata: if (s_cfg_rready) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   assign wr_acc      = s_cfg_awready;
   assign rd_acc      = s_cfg_arready;
   assign s_cfg_bresp = bresp_q;
   assign s_cfg_rresp = rresp_q;
   assign s_cfg_rdata = rdata_q;

   always_comb begin
      gctrl_d  = gctrl_q;
      win_d    = win_q;
      miss_clr = 1'b0;
      bresp_d  = bresp_q;
      rresp_d  = rd_acc ? (rd_dec.valid ? RespOkay : RespSlverr) : rresp_q;
      rdata_d  = rd_acc ? rd_val : rdata_q;
      if (wr_acc) begin
         bresp_d = wr_dec.valid ? RespOkay : RespSlverr;
         if (wr_dec.valid && !wr_dec.is_win) begin
            if (wr_ba == GctrlOfs)   gctrl_d  = wr_new[0];
            if (wr_ba == MissCntOfs) miss_clr = 1'b1;
         end else if (wr_dec.valid) begin
            for (int w = 0; w < NUM_WINDOWS; w++) begin
               if (wr_dec.win == 3'(w)) begin
                  case (wr_dec.field)
                     BaseOfs:   win_d[w].base   = wr_new & RegMask;
                     MaskOfs:   win_d[w].mask   = wr_new & RegMask;
                     OffsetOfs: win_d[w].offset = wr_new & RegMask;
                     WctrlOfs:  win_d[w].en     = wr_new[0];
                     default:   ;
                  endcase
               end
            end
         end
      end
   end

   // A clear in the same cycle as a miss still keeps that cycle's increment
   always_comb begin
      miss_sum    = {1'b0, (miss_clr ? 32'd0 : miss_cnt_q)} + 33'(aw_miss) + 33'(ar_miss);
      miss_cnt_d  = miss_sum[32] ? 32'hFFFF_FFFF : miss_sum[31:0];
      last_miss_d = aw_miss ? aw_miss_addr : (ar_miss ? ar_miss_addr : last_miss_q);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= StIdle;
         gctrl_q     <= 1'b0;
         miss_cnt_q  <= '0;
         last_miss_q <= '0;
         win_q       <= '0;
         bresp_q     <= RespOkay;
         rresp_q     <= RespOkay;
         rdata_q     <= '0;
      end else begin
         state_q     <= state_d;
         gctrl_q     <= gctrl_d;
         miss_cnt_q  <= miss_cnt_d;
         last_miss_q <= last_miss_d;
         win_q       <= win_d;
         bresp_q     <= bresp_d;
         rresp_q     <= rresp_d;
         rdata_q     <= rdata_d;
      end
   end

   axi_addr_remap_chan #(
      .ADDR_WIDTH  (ADDR_WIDTH),
      .USER_WIDTH  (USER_WIDTH),
      .NUM_WINDOWS (NUM_WINDOWS)
   ) u_aw_chan (
      .clk       (clk_i),
      .rst_n     (rst_ni),
      .glb_en    (gctrl_q),
      .win       (win_q),
      .up_addr   (up_aw_addr_i),
      .up_user   (up_aw_user_i),
      .up_valid  (up_aw_valid_i),
      .up_ready  (up_aw_ready_o),
      .dn_addr   (dn_aw_addr_o),
      .dn_user   (dn_aw_user_o),
      .dn_valid  (dn_aw_valid_o),
      .dn_ready  (dn_aw_ready_i),
      .miss      (aw_miss),
      .miss_addr (aw_miss_addr)
   );

   axi_addr_remap_chan #(
      .ADDR_WIDTH  (ADDR_WIDTH),
      .USER_WIDTH  (USER_WIDTH),
      .NUM_WINDOWS (NUM_WINDOWS)
   ) u_ar_chan (
      .clk       (clk_i),
      .rst_n     (rst_ni),
      .glb_en    (gctrl_q),
      .win       (win_q),
      .up_addr   (up_ar_addr_i),
      .up_user   (up_ar_user_i),
      .up_valid  (up_ar_valid_i),
      .up_ready  (up_ar_ready_o),
      .dn_addr   (dn_ar_addr_o),
      .dn_user   (dn_ar_user_o),
      .dn_valid  (dn_ar_valid_o),
      .dn_ready  (dn_ar_ready_i),
      .miss      (ar_miss),
      .miss_addr (ar_miss_addr)
   );

endmodule

// File: tb/tb_axi_addr_remapper.sv
// Directed and randomized checks of the address remapper against a first-match window model.
module tb_axi_addr_remapper;

   localparam int unsigned AW = 32;
   localparam int unsigned UW = 32;
   localparam int unsigned NW = 4;
   localparam int unsigned CW = 7;

   logic          clk = 1'b0;
   logic          rst_ni;
   logic [AW-1:0] up_aw_addr, dn_aw_addr, up_ar_addr, dn_ar_addr;
   logic [UW-1:0] up_aw_user, dn_aw_user, up_ar_user, dn_ar_user;
   logic          up_aw_valid, up_aw_ready, dn_aw_valid, dn_aw_ready;
   logic          up_ar_valid, up_ar_ready, dn_ar_valid, dn_ar_ready;
   logic [CW-1:0] s_cfg_awaddr, s_cfg_araddr;
   logic          s_cfg_awvalid, s_cfg_awready, s_cfg_wvalid, s_cfg_wready;
   logic [31:0]   s_cfg_wdata, s_cfg_rdata;
   logic [3:0]    s_cfg_wstrb;
   logic [1:0]    s_cfg_bresp, s_cfg_rresp;
   logic          s_cfg_bvalid, s_cfg_bready, s_cfg_arvalid, s_cfg_arready;
   logic          s_cfg_rvalid, s_cfg_rready;

   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0]     m_base[NW], m_mask[NW], m_off[NW];
   logic            m_en[NW];
   logic            m_gen;
   longint unsigned m_cnt;
   logic [31:0]     m_last;

   always #5 clk = ~clk;

   axi_addr_remapper #(
      .ADDR_WIDTH     (AW),
      .USER_WIDTH     (UW),
      .NUM_WINDOWS    (NW),
      .CFG_ADDR_WIDTH (CW)
   ) dut (
      .clk_i         (clk),
      .rst_ni        (rst_ni),
      .up_aw_addr_i  (up_aw_addr),
      .up_aw_user_i  (up_aw_user),
      .up_aw_valid_i (up_aw_valid),
      .up_aw_ready_o (up_aw_ready),
      .dn_aw_addr_o  (dn_aw_addr),
      .dn_aw_user_o  (dn_aw_user),
      .dn_aw_valid_o (dn_aw_valid),
      .dn_aw_ready_i (dn_aw_ready),
      .up_ar_addr_i  (up_ar_addr),
      .up_ar_user_i  (up_ar_user),
      .up_ar_valid_i (up_ar_valid),
      .up_ar_ready_o (up_ar_ready),
      .dn_ar_addr_o  (dn_ar_addr),
      .dn_ar_user_o  (dn_ar_user),
      .dn_ar_valid_o (dn_ar_valid),
      .dn_ar_ready_i (dn_ar_ready),
      .s_cfg_awaddr  (s_cfg_awaddr),
      .s_cfg_awvalid (s_cfg_awvalid),
      .s_cfg_awready (s_cfg_awready),
      .s_cfg_wdata   (s_cfg_wdata),
      .s_cfg_wstrb   (s_cfg_wstrb),
      .s_cfg_wvalid  (s_cfg_wvalid),
      .s_cfg_wready  (s_cfg_wready),
      .s_cfg_bresp   (s_cfg_bresp),
      .s_cfg_bvalid  (s_cfg_bvalid),
      .s_cfg_bready  (s_cfg_bready),
      .s_cfg_araddr  (s_cfg_araddr),
      .s_cfg_arvalid (s_cfg_arvalid),
      .s_cfg_arready (s_cfg_arready),
      .s_cfg_rdata   (s_cfg_rdata),
      .s_cfg_rresp   (s_cfg_rresp),
      .s_cfg_rvalid  (s_cfg_rvalid),
      .s_cfg_rready  (s_cfg_rready)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // ---------------- reference model ----------------
   task automatic model_reset();
      for (int w = 0; w < NW; w++) begin
         m_base[w] = '0; m_mask[w] = '0; m_off[w] = '0; m_en[w] = 1'b0;
      end
      m_gen = 1'b0; m_cnt = 0; m_last = '0;
   endtask

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                         input logic [3:0] s);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
      return r;
   endfunction

   function automatic bit in_range(input logic [CW-1:0] a);
      int unsigned ba;
      ba = int'(a) & ~3;
      return (ba < 12) || (ba >= 16 && (ba - 16) / 16 < NW);
   endfunction

   task automatic model_write(input logic [CW-1:0] a, input logic [31:0] d, input logic [3:0] s);
      int unsigned ba, w, f;
      ba = int'(a) & ~3;
      if (ba == 0 && s[0]) m_gen = d[0];
      if (ba == 4) m_cnt = 0;
      if (ba >= 16 && (ba - 16) / 16 < NW) begin
         w = (ba - 16) / 16;
         f = (ba - 16) % 16;
         if (f == 0) m_base[w] = merge(m_base[w], d, s);
         if (f == 4) m_mask[w] = merge(m_mask[w], d, s);
         if (f == 8) m_off[w]  = merge(m_off[w], d, s);
         if (f == 12 && s[0]) m_en[w] = d[0];
      end
   endtask

   function automatic logic [31:0] model_read(input logic [CW-1:0] a);
      int unsigned ba, w, f;
      ba = int'(a) & ~3;
      if (ba == 0) return {31'b0, m_gen};
      if (ba == 4) return m_cnt[31:0];
      if (ba == 8) return m_last;
      if (ba >= 16 && (ba - 16) / 16 < NW) begin
         w = (ba - 16) / 16;
         f = (ba - 16) % 16;
         if (f == 0) return m_base[w];
         if (f == 4) return m_mask[w];
         if (f == 8) return m_off[w];
         return {31'b0, m_en[w]};
      end
      return 32'h0;
   endfunction

   // First enabled matching window in index order translates the address
   function automatic logic [31:0] model_xlat(input logic [31:0] a, output bit hit);
      hit = 1'b0;
      if (m_gen) begin
         for (int w = 0; w < NW; w++) begin
            if (m_en[w] && ((a & m_mask[w]) == (m_base[w] & m_mask[w]))) begin
               hit = 1'b1;
               return a + m_off[w];
            end
         end
      end
      return a;
   endfunction

   task automatic model_miss(input bit aw_m, input logic [31:0] aw_a,
                             input bit ar_m, input logic [31:0] ar_a);
      if (!m_gen) return;
      m_cnt = m_cnt + aw_m + ar_m;
      if (m_cnt > 64'hFFFF_FFFF) m_cnt = 64'hFFFF_FFFF;
      if (aw_m) m_last = aw_a;
      else if (ar_m) m_last = ar_a;
   endtask

   // ---------------- bus tasks ----------------
   task automatic cfg_write(input logic [CW-1:0] a, input logic [31:0] d, input logic [3:0] s);
      int n;
      s_cfg_awaddr = a; s_cfg_wdata = d; s_cfg_wstrb = s;
      s_cfg_awvalid = 1'b1; s_cfg_wvalid = 1'b1;
      #1;
      n = 0;
      while (!(s_cfg_awready && s_cfg_wready) && n < 20) begin @(posedge clk); #1; n++; end
      check("cfg_aw_accept", s_cfg_awready, 1'b1);
      @(posedge clk); #1;
      s_cfg_awvalid = 1'b0; s_cfg_wvalid = 1'b0;
      n = 0;
      while (!s_cfg_bvalid && n < 20) begin @(posedge clk); #1; n++; end
      check("cfg_bvalid", s_cfg_bvalid, 1'b1);
      check("cfg_bresp", s_cfg_bresp, in_range(a) ? 32'h0 : 32'h2);
      s_cfg_bready = 1'b1;
      @(posedge clk); #1;
      s_cfg_bready = 1'b0;
      model_write(a, d, s);
   endtask

   task automatic cfg_read_check(input logic [CW-1:0] a, input string tag);
      int n;
      s_cfg_araddr = a; s_cfg_arvalid = 1'b1;
      #1;
      n = 0;
      while (!s_cfg_arready && n < 20) begin @(posedge clk); #1; n++; end
      check({tag, "_ar_accept"}, s_cfg_arready, 1'b1);
      @(posedge clk); #1;
      s_cfg_arvalid = 1'b0;
      n = 0;
      while (!s_cfg_rvalid && n < 20) begin @(posedge clk); #1; n++; end
      check({tag, "_rvalid"}, s_cfg_rvalid, 1'b1);
      check(tag, s_cfg_rdata, model_read(a));
      check({tag, "_rresp"}, s_cfg_rresp, in_range(a) ? 32'h0 : 32'h2);
      s_cfg_rready = 1'b1;
      @(posedge clk); #1;
      s_cfg_rready = 1'b0;
   endtask

   task automatic beat(input bit is_ar, input logic [31:0] a, input logic [31:0] u);
      logic [31:0] e;
      bit          h;
      int          n;
      e = model_xlat(a, h);
      if (is_ar) begin up_ar_addr = a; up_ar_user = u; up_ar_valid = 1'b1; end
      else       begin up_aw_addr = a; up_aw_user = u; up_aw_valid = 1'b1; end
      #1;
      n = 0;
      while (!(is_ar ? up_ar_ready : up_aw_ready) && n < 20) begin @(posedge clk); #1; n++; end
      check("up_ready", is_ar ? up_ar_ready : up_aw_ready, 1'b1);
      @(posedge clk); #1;
      up_ar_valid = 1'b0; up_aw_valid = 1'b0;
      check(is_ar ? "ar_dn_valid" : "aw_dn_valid", is_ar ? dn_ar_valid : dn_aw_valid, 1'b1);
      check(is_ar ? "ar_dn_addr" : "aw_dn_addr", is_ar ? dn_ar_addr : dn_aw_addr, e);
      check(is_ar ? "ar_dn_user" : "aw_dn_user", is_ar ? dn_ar_user : dn_aw_user, u);
      if (is_ar) model_miss(1'b0, '0, !h && m_gen, a);
      else       model_miss(!h && m_gen, a, 1'b0, '0);
      @(posedge clk); #1;
   endtask

   initial begin
      #200_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      logic [31:0] e1, e2, a, u;
      bit          h1, h2;
      int          wsel;

      rst_ni = 1'b0;
      up_aw_addr = '0; up_aw_user = '0; up_aw_valid = 1'b0; dn_aw_ready = 1'b1;
      up_ar_addr = '0; up_ar_user = '0; up_ar_valid = 1'b0; dn_ar_ready = 1'b1;
      s_cfg_awaddr = '0; s_cfg_awvalid = 1'b0; s_cfg_wdata = '0; s_cfg_wstrb = '0;
      s_cfg_wvalid = 1'b0; s_cfg_bready = 1'b0; s_cfg_araddr = '0; s_cfg_arvalid = 1'b0;
      s_cfg_rready = 1'b0;
      model_reset();
      #22;
      check("rst_dn_aw_valid", dn_aw_valid, 1'b0);
      check("rst_dn_ar_valid", dn_ar_valid, 1'b0);
      check("rst_awready", s_cfg_awready, 1'b0);
      check("rst_wready", s_cfg_wready, 1'b0);
      check("rst_arready", s_cfg_arready, 1'b0);
      check("rst_bvalid", s_cfg_bvalid, 1'b0);
      check("rst_rvalid", s_cfg_rvalid, 1'b0);
      rst_ni = 1'b1;
      @(posedge clk); #1;

      // Unprogrammed: pass-through, nothing counted
      beat(1'b1, 32'h1000_0040, 32'h0000_0011);
      cfg_read_check(7'h04, "miss_cnt_after_reset");
      cfg_read_check(7'h00, "gctrl_after_reset");

      // Basic window 0
      cfg_write(7'h10, 32'h0000_0000, 4'hF);
      cfg_write(7'h14, 32'hFF00_0000, 4'hF);
      cfg_write(7'h18, 32'h1800_0000, 4'hF);
      cfg_write(7'h1C, 32'h1, 4'hF);
      cfg_write(7'h00, 32'h1, 4'hF);
      beat(1'b0, 32'h0000_1234, 32'hCAFE_0001);
      check("basic_win_literal", dn_aw_addr, 32'h1800_1234);

      // Priority: both windows match, window 0 wins
      cfg_write(7'h20, 32'h2000_0000, 4'hF);
      cfg_write(7'h24, 32'hF000_0000, 4'hF);
      cfg_write(7'h28, 32'h0000_0010, 4'hF);
      cfg_write(7'h2C, 32'h1, 4'hF);
      cfg_write(7'h10, 32'h2000_0000, 4'hF);
      cfg_write(7'h14, 32'hF000_0000, 4'hF);
      cfg_write(7'h18, 32'h0000_0020, 4'hF);
      beat(1'b1, 32'h2000_0000, 32'h2);
      // Wrap-around translation
      cfg_write(7'h10, 32'hFFFF_0000, 4'hF);
      cfg_write(7'h14, 32'hFFFF_0000, 4'hF);
      beat(1'b0, 32'hFFFF_FFF0, 32'h3);

      // Same-cycle misses on both channels
      cfg_write(7'h04, 32'h0, 4'hF);
      e1 = model_xlat(32'hA000_0000, h1);
      e2 = model_xlat(32'hB000_0000, h2);
      up_aw_addr = 32'hA000_0000; up_aw_user = 32'h4; up_aw_valid = 1'b1;
      up_ar_addr = 32'hB000_0000; up_ar_user = 32'h5; up_ar_valid = 1'b1;
      @(posedge clk); #1;
      up_aw_valid = 1'b0; up_ar_valid = 1'b0;
      check("dual_aw_addr", dn_aw_addr, e1);
      check("dual_ar_addr", dn_ar_addr, e2);
      model_miss(!h1, 32'hA000_0000, !h2, 32'hB000_0000);
      @(posedge clk); #1;
      cfg_read_check(7'h04, "miss_cnt_dual");
      cfg_read_check(7'h08, "last_miss_dual");
      cfg_write(7'h04, 32'h1234_5678, 4'h1);
      cfg_read_check(7'h04, "miss_cnt_cleared");

      // Backpressure on AW
      dn_aw_ready = 1'b0;
      e1 = model_xlat(32'hFFFF_0100, h1);
      e2 = model_xlat(32'hFFFF_0200, h2);
      up_aw_addr = 32'hFFFF_0100; up_aw_user = 32'h61; up_aw_valid = 1'b1;
      #1;
      check("bp_ready_empty", up_aw_ready, 1'b1);
      @(posedge clk); #1;
      up_aw_addr = 32'hFFFF_0200; up_aw_user = 32'h62;
      #1;
      check("bp_ready_full", up_aw_ready, 1'b0);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         check("bp_hold_valid", dn_aw_valid, 1'b1);
         check("bp_hold_addr", dn_aw_addr, e1);
         check("bp_hold_user", dn_aw_user, 32'h61);
         check("bp_hold_upready", up_aw_ready, 1'b0);
      end
      dn_aw_ready = 1'b1;
      #1;
      check("bp_release_ready", up_aw_ready, 1'b1);
      @(posedge clk); #1;
      up_aw_valid = 1'b0;
      check("bp_second_valid", dn_aw_valid, 1'b1);
      check("bp_second_addr", dn_aw_addr, e2);
      check("bp_second_user", dn_aw_user, 32'h62);
      @(posedge clk); #1;
      check("bp_drained", dn_aw_valid, 1'b0);
      model_miss(!h1, 32'hFFFF_0100, 1'b0, '0);
      model_miss(!h2, 32'hFFFF_0200, 1'b0, '0);

      // Config write waits for wvalid
      s_cfg_awaddr = 7'h30; s_cfg_wdata = 32'h5555_0000; s_cfg_wstrb = 4'hF;
      s_cfg_awvalid = 1'b1; s_cfg_wvalid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         check("aw_only_awready", s_cfg_awready, 1'b0);
         check("aw_only_wready", s_cfg_wready, 1'b0);
         @(posedge clk); #1;
      end
      s_cfg_wvalid = 1'b1;
      #1;
      check("aw_w_awready", s_cfg_awready, 1'b1);
      check("aw_w_wready", s_cfg_wready, 1'b1);
      @(posedge clk); #1;
      s_cfg_awvalid = 1'b0; s_cfg_wvalid = 1'b0;
      check("delayed_bvalid", s_cfg_bvalid, 1'b1);
      s_cfg_bready = 1'b1;
      @(posedge clk); #1;
      s_cfg_bready = 1'b0;
      model_write(7'h30, 32'h5555_0000, 4'hF);
      cfg_read_check(7'h30, "delayed_write_base2");

      // Out-of-range access and byte strobes
      cfg_write(7'h7C, 32'hDEAD_BEEF, 4'hF);
      cfg_read_check(7'h7C, "oor_read");
      cfg_read_check(7'h0C, "hole_read");
      cfg_write(7'h30, 32'h1122_3344, 4'hF);
      cfg_write(7'h30, 32'hAABB_CCDD, 4'b0010);
      cfg_read_check(7'h30, "strobe_byte1");

      // Write wins over a simultaneous read; read is held off during the response
      s_cfg_awaddr = 7'h08; s_cfg_wdata = 32'h0; s_cfg_wstrb = 4'hF;
      s_cfg_awvalid = 1'b1; s_cfg_wvalid = 1'b1;
      s_cfg_araddr = 7'h30; s_cfg_arvalid = 1'b1;
      #1;
      check("wfirst_awready", s_cfg_awready, 1'b1);
      check("wfirst_arready", s_cfg_arready, 1'b0);
      @(posedge clk); #1;
      s_cfg_awvalid = 1'b0; s_cfg_wvalid = 1'b0;
      check("wfirst_bvalid", s_cfg_bvalid, 1'b1);
      check("wresp_blocks_read", s_cfg_arready, 1'b0);
      s_cfg_bready = 1'b1;
      @(posedge clk); #1;
      s_cfg_bready = 1'b0;
      s_cfg_arvalid = 1'b0;
      cfg_read_check(7'h30, "read_after_write");

      // Randomized windows and traffic, enable on then off
      for (int w = 0; w < NW; w++) begin
         case ($urandom_range(0, 2))
            0:       a = 32'hFF00_0000;
            1:       a = 32'hFFF0_0000;
            default: a = 32'hF000_0000;
         endcase
         cfg_write(CW'(16 + 16 * w), $urandom, 4'hF);
         cfg_write(CW'(20 + 16 * w), a, 4'hF);
         cfg_write(CW'(24 + 16 * w), $urandom, 4'hF);
         cfg_write(CW'(28 + 16 * w), 32'($urandom_range(0, 1)), 4'hF);
      end
      cfg_read_check(7'h24, "rand_mask1_readback");
      for (int r = 0; r < 2; r++) begin
         cfg_write(7'h00, (r == 0) ? 32'h1 : 32'h0, 4'hF);
         for (int i = 0; i < 20; i++) begin
            wsel = $urandom_range(0, NW - 1);
            if ($urandom_range(0, 2) == 0) a = $urandom;
            else a = (m_base[wsel] & m_mask[wsel]) | ($urandom & ~m_mask[wsel]);
            u = $urandom;
            beat($urandom_range(0, 1) == 1, a, u);
         end
         cfg_read_check(7'h04, "rand_miss_cnt");
         cfg_read_check(7'h08, "rand_last_miss");
      end

      // Asynchronous reset with a beat parked in the AR slice
      dn_ar_ready = 1'b0;
      up_ar_addr = 32'h0BAD_0000; up_ar_valid = 1'b1;
      @(posedge clk); #1;
      up_ar_valid = 1'b0;
      check("pre_reset_ar_valid", dn_ar_valid, 1'b1);
      #2;
      rst_ni = 1'b0;
      #1;
      check("async_reset_ar_valid", dn_ar_valid, 1'b0);
      check("async_reset_aw_valid", dn_aw_valid, 1'b0);
      model_reset();
      @(posedge clk); #1;
      rst_ni = 1'b1;
      dn_ar_ready = 1'b1;
      @(posedge clk); #1;
      cfg_read_check(7'h00, "gctrl_after_midreset");
      cfg_read_check(7'h10, "base0_after_midreset");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
